// File: rtl/preamble_rate_detector_pkg.sv
// Shared definitions for the preamble training receive path: FSM states,
// error codes and a constant log2 helper for power-of-two sizing.
package preamble_rate_detector_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARM     = 2'b01,
        MEASURE = 2'b10,
        RESULT  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_FIRST_TO = 2'b01,
        ERR_INT_TO   = 2'b10,
        ERR_TOL      = 2'b11
    } err_code_e;

    // Exact log2 of a power of two; only evaluated on parameters.
    function automatic int unsigned log2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) == v) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/preamble_rate_detector_sync_edge_det.sv
// Two-flop synchronizer plus a delay flop; edge_o pulses for one cycle on
// every transition of the synchronized line, either polarity.
module sync_edge_det #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic edge_o
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
            s3_q <= RST_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign edge_o = s2_q ^ s3_q;

endmodule

// File: rtl/preamble_rate_detector.sv
// Measures transition spacing on the training line, averages MEAS_EDGES
// intervals under a tolerance check and reports the recovered bit divider.
module preamble_rate_detector
    import preamble_rate_detector_pkg::*;
#(
    parameter int unsigned DIV_WIDTH          = 8,
    parameter int unsigned MEAS_EDGES         = 8,
    parameter int unsigned TOL                = 1,
    parameter int unsigned FIRST_EDGE_TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 training_in,
    output logic [DIV_WIDTH-1:0] clk_div,
    output logic                 done,
    output logic                 error,
    output logic [1:0]           err_code,
    output logic                 busy,
    output logic                 locked
);

    localparam int unsigned LOG    = log2(MEAS_EDGES);
    localparam int unsigned ICNT_W = DIV_WIDTH + 1;
    localparam int unsigned SUM_W  = DIV_WIDTH + 1 + LOG;
    localparam int unsigned CNT_W  = LOG + 1;
    localparam int unsigned WAIT_W = (FIRST_EDGE_TIMEOUT > 1) ? $clog2(FIRST_EDGE_TIMEOUT) : 1;

    localparam logic [ICNT_W-1:0] ICNT_MAX  = {1'b1, {DIV_WIDTH{1'b0}}};
    localparam logic [ICNT_W-1:0] TOL_V     = ICNT_W'(TOL);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MEAS_EDGES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((FIRST_EDGE_TIMEOUT == 0) ? 0 : FIRST_EDGE_TIMEOUT - 1);
    localparam bit TIMEOUT_EN = (FIRST_EDGE_TIMEOUT != 0);

    state_e               state_q;
    err_code_e            err_q;
    logic [ICNT_W-1:0]    icnt_q, ref_q, diff;
    logic [SUM_W-1:0]     sum_q, sum_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [WAIT_W-1:0]    wcnt_q;
    logic [DIV_WIDTH-1:0] clk_div_q, clk_div_d;
    logic                 done_q, error_q, locked_q;
    logic                 edge_s, interval_ok;

    sync_edge_det #(.RST_VAL(1'b1)) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (training_in),
        .edge_o (edge_s)
    );

    // The first accepted interval defines the reference, so it always passes.
    always_comb begin
        diff        = (icnt_q >= ref_q) ? (icnt_q - ref_q) : (ref_q - icnt_q);
        interval_ok = (cnt_q == '0) || (diff <= TOL_V);
        sum_d       = sum_q + SUM_W'(icnt_q);
        clk_div_d   = DIV_WIDTH'(sum_q[SUM_W-1:LOG] - ICNT_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            err_q     <= ERR_NONE;
            icnt_q    <= '0;
            ref_q     <= '0;
            sum_q     <= '0;
            cnt_q     <= '0;
            wcnt_q    <= '0;
            clk_div_q <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            icnt_q  <= edge_s ? ICNT_W'(1) : icnt_q + ICNT_W'(1);
            if (start) begin
                state_q  <= ARM;
                locked_q <= 1'b0;
                err_q    <= ERR_NONE;
                wcnt_q   <= '0;
                icnt_q   <= '0;
                cnt_q    <= '0;
                sum_q    <= '0;
            end else begin
                case (state_q)
                    IDLE: ;
                    ARM: begin
                        if (edge_s) begin
                            state_q <= MEASURE;
                        end else if (TIMEOUT_EN && wcnt_q == WAIT_LAST) begin
                            state_q <= IDLE;
                            error_q <= 1'b1;
                            err_q   <= ERR_FIRST_TO;
                        end else begin
                            wcnt_q <= wcnt_q + WAIT_W'(1);
                        end
                    end
                    MEASURE: begin
                        // An edge landing exactly at the maximum count still counts.
                        if (edge_s) begin
                            if (!interval_ok) begin
                                state_q <= IDLE;
                                error_q <= 1'b1;
                                err_q   <= ERR_TOL;
                            end else begin
                                sum_q <= sum_d;
                                cnt_q <= cnt_q + CNT_W'(1);
                                if (cnt_q == '0) ref_q <= icnt_q;
                                if (cnt_q == CNT_LAST) state_q <= RESULT;
                            end
                        end else if (icnt_q == ICNT_MAX) begin
                            state_q <= IDLE;
                            error_q <= 1'b1;
                            err_q   <= ERR_INT_TO;
                        end
                    end
                    RESULT: begin
                        clk_div_q <= clk_div_d;
                        done_q    <= 1'b1;
                        locked_q  <= 1'b1;
                        state_q   <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign clk_div  = clk_div_q;
    assign done     = done_q;
    assign error    = error_q;
    assign err_code = err_q;
    assign locked   = locked_q;
    assign busy     = (state_q == ARM) || (state_q == MEASURE);

endmodule

// File: tb/tb_preamble_rate_detector.sv
// Scenario bench for preamble_rate_detector: a reference model predicts each
// measurement outcome, and a monitor matches done/error pulses against it.
module tb_preamble_rate_detector;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       training_in = 1'b1;
    logic [7:0] clk_div;
    logic       done, error, busy, locked;
    logic [1:0] err_code;

    int ntests = 0;
    int nfail  = 0;

    typedef struct {
        bit         is_err;
        logic [1:0] code;
        logic [7:0] div;
    } exp_t;

    exp_t sb[$];

    preamble_rate_detector #(
        .DIV_WIDTH          (8),
        .MEAS_EDGES         (8),
        .TOL                (1),
        .FIRST_EDGE_TIMEOUT (4096)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .training_in (training_in),
        .clk_div     (clk_div),
        .done        (done),
        .error       (error),
        .err_code    (err_code),
        .busy        (busy),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Outcome of one measurement given the interval sequence, line stuck after.
    function automatic exp_t predict(input int iv[$]);
        exp_t e;
        int   r, s, d;
        e.is_err = 1'b1;
        e.code   = 2'b10;
        e.div    = 8'd0;
        r = 0;
        s = 0;
        for (int k = 0; k < iv.size() && k < 8; k++) begin
            if (iv[k] > 256) return e;
            if (k == 0) r = iv[0];
            d = (iv[k] > r) ? iv[k] - r : r - iv[k];
            if (d > 1) begin
                e.code = 2'b11;
                return e;
            end
            s += iv[k];
            if (k == 7) begin
                e.is_err = 1'b0;
                e.code   = 2'b00;
                e.div    = 8'(s / 8 - 1);
                return e;
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && (done || error)) begin
            exp_t e;
            ntests++;
            if (sb.size() == 0) begin
                nfail++;
                $display("FAIL sb_unexpected: done=%0b error=%0b code=%0b, required no pulse",
                         done, error, err_code);
            end else begin
                e = sb.pop_front();
                if (error !== e.is_err || done !== !e.is_err) begin
                    nfail++;
                    $display("FAIL sb_kind: done=%0b error=%0b, required error=%0b",
                             done, error, e.is_err);
                end else if (e.is_err && (err_code !== e.code || locked !== 1'b0)) begin
                    nfail++;
                    $display("FAIL sb_err: code=%0b locked=%0b, required code=%0b locked=0",
                             err_code, locked, e.code);
                end else if (!e.is_err && (clk_div !== e.div || locked !== 1'b1)) begin
                    nfail++;
                    $display("FAIL sb_div: clk_div=%0d locked=%0b, required clk_div=%0d locked=1",
                             clk_div, locked, e.div);
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One transition, then one more after each interval; returns on the last.
    task automatic drive_intervals(input int iv[$]);
        @(negedge clk);
        training_in = ~training_in;
        foreach (iv[k]) begin
            repeat (iv[k]) @(negedge clk);
            training_in = ~training_in;
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int k = 0; k < budget && sb.size() != 0; k++) @(negedge clk);
        ntests++;
        if (sb.size() != 0) begin
            nfail++;
            $display("FAIL %s: %0d outcomes still pending after %0d cycles, required 0",
                     name, sb.size(), budget);
            sb.delete();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        ntests++;
        if ({clk_div, done, error, err_code, busy, locked} !== 14'd0) begin
            nfail++;
            $display("FAIL reset_vals: div=%0d done=%0b err=%0b code=%0b busy=%0b lock=%0b, required all 0",
                     clk_div, done, error, err_code, busy, locked);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        ntests++;
        if ({done, error, busy, locked} !== 4'd0) begin
            nfail++;
            $display("FAIL post_reset_idle: done=%0b err=%0b busy=%0b lock=%0b, required 0",
                     done, error, busy, locked);
        end
    endtask

    task automatic test_ideal();
        int   iv[$];
        int   lat;
        exp_t e;
        repeat (8) iv.push_back(5);
        e = predict(iv);
        sb.push_back(e);
        pulse_start();
        drive_intervals(iv);
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
        ntests++;
        if (lat != 4) begin
            nfail++;
            $display("FAIL ideal_latency: done after %0d cycles, required 4", lat);
        end
        repeat (4) begin
            repeat (5) @(negedge clk);
            training_in = ~training_in;
        end
        repeat (10) @(negedge clk);
        ntests++;
        if (locked !== 1'b1 || clk_div !== 8'd4 || busy !== 1'b0) begin
            nfail++;
            $display("FAIL ideal_hold: locked=%0b clk_div=%0d busy=%0b, required 1/4/0",
                     locked, clk_div, busy);
        end
        wait_drain("ideal_drain", 20);
    endtask

    task automatic test_jitter();
        int iv[$];
        iv = {5, 6, 4, 5, 5, 5, 6, 4};
        sb.push_back(predict(iv));
        pulse_start();
        drive_intervals(iv);
        wait_drain("jitter_drain", 20);
        ntests++;
        if (clk_div !== 8'd4) begin
            nfail++;
            $display("FAIL jitter_div: clk_div=%0d, required 4", clk_div);
        end
    endtask

    task automatic test_tolerance();
        int iv[$];
        int lat;
        iv = {5, 5, 8};
        sb.push_back(predict(iv));
        pulse_start();
        drive_intervals(iv);
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (error) begin
                lat = k;
                break;
            end
        end
        ntests++;
        if (lat != 3) begin
            nfail++;
            $display("FAIL tol_latency: error after %0d cycles, required 3", lat);
        end
        repeat (20) @(negedge clk);
        ntests++;
        if (err_code !== 2'b11 || locked !== 1'b0 || busy !== 1'b0) begin
            nfail++;
            $display("FAIL tol_hold: code=%0b locked=%0b busy=%0b, required 11/0/0",
                     err_code, locked, busy);
        end
        wait_drain("tol_drain", 5);
    endtask

    task automatic test_first_timeout();
        exp_t e;
        int   k;
        e.is_err = 1'b1;
        e.code   = 2'b01;
        e.div    = 8'd0;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        ntests++;
        if (busy !== 1'b1 || err_code !== 2'b00) begin
            nfail++;
            $display("FAIL arm_entry: busy=%0b code=%0b, required busy=1 code=00", busy, err_code);
        end
        while (!error && k < 5000) begin
            @(negedge clk);
            k++;
        end
        ntests++;
        if (k != 4097 || busy !== 1'b0) begin
            nfail++;
            $display("FAIL first_to_time: error after %0d cycles busy=%0b, required 4097 busy=0",
                     k, busy);
        end
        wait_drain("first_to_drain", 5);
    endtask

    task automatic test_interval_timeout();
        int iv[$];
        iv = {5, 5};
        sb.push_back(predict(iv));
        pulse_start();
        drive_intervals(iv);
        wait_drain("int_to_drain", 400);
        ntests++;
        if (err_code !== 2'b10) begin
            nfail++;
            $display("FAIL int_to_code: code=%0b, required 10", err_code);
        end
    endtask

    task automatic test_boundary();
        int iv[$];
        repeat (8) iv.push_back(256);
        sb.push_back(predict(iv));
        pulse_start();
        drive_intervals(iv);
        wait_drain("boundary_drain", 20);
        ntests++;
        if (clk_div !== 8'd255 || locked !== 1'b1) begin
            nfail++;
            $display("FAIL boundary_div: clk_div=%0d locked=%0b, required 255/1", clk_div, locked);
        end
    endtask

    task automatic test_abort();
        int iv[$];
        iv = {7, 7, 7, 7};
        pulse_start();
        drive_intervals(iv);
        repeat (6) @(negedge clk);
        iv.delete();
        repeat (8) iv.push_back(3);
        sb.push_back(predict(iv));
        pulse_start();
        ntests++;
        if (locked !== 1'b0 || busy !== 1'b1) begin
            nfail++;
            $display("FAIL abort_rearm: locked=%0b busy=%0b, required 0/1", locked, busy);
        end
        drive_intervals(iv);
        wait_drain("abort_drain", 20);
        ntests++;
        if (clk_div !== 8'd2) begin
            nfail++;
            $display("FAIL abort_div: clk_div=%0d, required 2", clk_div);
        end
    endtask

    task automatic test_reset_mid();
        int iv[$];
        iv = {5, 5, 5};
        pulse_start();
        drive_intervals(iv);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        ntests++;
        if ({clk_div, done, error, err_code, busy, locked} !== 14'd0) begin
            nfail++;
            $display("FAIL reset_mid: div=%0d done=%0b err=%0b code=%0b busy=%0b lock=%0b, required all 0",
                     clk_div, done, error, err_code, busy, locked);
        end
        training_in = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        iv = {5, 5, 5, 5};
        drive_intervals(iv);
        repeat (300) @(negedge clk);
        ntests++;
        if (busy !== 1'b0 || error !== 1'b0 || err_code !== 2'b00) begin
            nfail++;
            $display("FAIL reset_idle: busy=%0b err=%0b code=%0b, required 0/0/00",
                     busy, error, err_code);
        end
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_jitter();
        test_tolerance();
        test_first_timeout();
        test_interval_timeout();
        test_boundary();
        test_abort();
        test_reset_mid();
        wait_drain("final_drain", 5);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
